// File: rtl/vga_rect_fill.sv
// Rectangle fill engine for the 160x120 1-bit VGA frame buffer.
// The CPU programs two corners, a colour and a START strobe. The engine then
// issues the driver's Y / X / pixel-data register writes, one write per cycle,
// until every pixel of the rectangle has been written.
module vga_rect_fill #(
    parameter logic [7:0] BASE_ADDR  = 8'hC0,
    parameter logic [7:0] VGA_Y_ADDR = 8'hB0,
    parameter logic [7:0] VGA_X_ADDR = 8'hB1,
    parameter logic [7:0] VGA_D_ADDR = 8'hB2,
    parameter logic [7:0] X_MAX      = 8'd159,
    parameter logic [7:0] Y_MAX      = 8'd119
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic [7:0] BUS_DATA_OUT,
    output logic [7:0] VGA_ADDR,
    output logic [7:0] VGA_DATA,
    output logic       VGA_WE,
    output logic       BUSY,
    output logic       DONE_IRQ
);

    localparam logic [7:0] ADDR_X0   = BASE_ADDR;
    localparam logic [7:0] ADDR_Y0   = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_X1   = BASE_ADDR + 8'd2;
    localparam logic [7:0] ADDR_Y1   = BASE_ADDR + 8'd3;
    localparam logic [7:0] ADDR_COL  = BASE_ADDR + 8'd4;
    localparam logic [7:0] ADDR_CTRL = BASE_ADDR + 8'd5;

    // The state names the write currently presented on the VGA outputs.
    typedef enum logic [2:0] {
        StIdle,
        StSetY,
        StSetX,
        StWrPix,
        StDone
    } state_e;

    state_e     state_q, state_d;

    // Command registers
    logic [7:0] x0_q, y0_q, x1_q, y1_q;
    logic       colour_q;

    // Latched fill bounds and walking pixel position
    logic [7:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d;
    logic [7:0] y_lo_q, y_lo_d, y_hi_q, y_hi_d;
    logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] vga_addr_q, vga_addr_d;
    logic [7:0] vga_data_q, vga_data_d;
    logic       vga_we_q, vga_we_d;
    logic [7:0] rdata_q;

    logic       ctrl_wr, start, abort;
    logic [7:0] x_min, x_max, y_min, y_max;
    logic [7:0] x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic       clamp_err;
    logic [7:0] x_next, y_next;

    assign ctrl_wr = BUS_WE && (BUS_ADDR == ADDR_CTRL);
    assign start   = ctrl_wr && BUS_DATA[0];
    assign abort   = ctrl_wr && BUS_DATA[1];

    assign x_next = cur_x_q + 8'd1;
    assign y_next = cur_y_q + 8'd1;

    // Order the corners and clamp them to the visible frame.
    always_comb begin
        x_min     = (x0_q < x1_q) ? x0_q : x1_q;
        x_max     = (x0_q < x1_q) ? x1_q : x0_q;
        y_min     = (y0_q < y1_q) ? y0_q : y1_q;
        y_max     = (y0_q < y1_q) ? y1_q : y0_q;
        x_lo_c    = (x_min > X_MAX) ? X_MAX : x_min;
        x_hi_c    = (x_max > X_MAX) ? X_MAX : x_max;
        y_lo_c    = (y_min > Y_MAX) ? Y_MAX : y_min;
        y_hi_c    = (y_max > Y_MAX) ? Y_MAX : y_max;
        // A max above the limit covers every out-of-range case.
        clamp_err = (x_max > X_MAX) || (y_max > Y_MAX);
    end

    // Command register writes; frozen while a fill is running.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x0_q     <= 8'h00;
            y0_q     <= 8'h00;
            x1_q     <= 8'h00;
            y1_q     <= 8'h00;
            colour_q <= 1'b0;
        end else if (BUS_WE && !busy_q) begin
            if (BUS_ADDR == ADDR_X0)  x0_q     <= BUS_DATA;
            if (BUS_ADDR == ADDR_Y0)  y0_q     <= BUS_DATA;
            if (BUS_ADDR == ADDR_X1)  x1_q     <= BUS_DATA;
            if (BUS_ADDR == ADDR_Y1)  y1_q     <= BUS_DATA;
            if (BUS_ADDR == ADDR_COL) colour_q <= BUS_DATA[0];
        end
    end

    // Status read-back, registered every cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= (BUS_ADDR == ADDR_CTRL) ? {6'b0, err_q, busy_q} : 8'h00;
        end
    end

    // Next-state and next-output logic; VGA outputs are computed one cycle
    // ahead so the first write lands in the cycle after START.
    always_comb begin
        state_d    = state_q;
        x_lo_d     = x_lo_q;
        x_hi_d     = x_hi_q;
        y_lo_d     = y_lo_q;
        y_hi_d     = y_hi_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        vga_addr_d = vga_addr_q;
        vga_data_d = vga_data_q;
        vga_we_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    x_lo_d     = x_lo_c;
                    x_hi_d     = x_hi_c;
                    y_lo_d     = y_lo_c;
                    y_hi_d     = y_hi_c;
                    cur_x_d    = x_lo_c;
                    cur_y_d    = y_lo_c;
                    err_d      = clamp_err;
                    busy_d     = 1'b1;
                    state_d    = StSetY;
                    vga_addr_d = VGA_Y_ADDR;
                    vga_data_d = {1'b0, y_lo_c[6:0]};
                    vga_we_d   = 1'b1;
                end
            end
            StSetY: begin
                state_d    = StSetX;
                vga_addr_d = VGA_X_ADDR;
                vga_data_d = cur_x_q;
                vga_we_d   = 1'b1;
            end
            StSetX: begin
                state_d    = StWrPix;
                vga_addr_d = VGA_D_ADDR;
                vga_data_d = {7'b0, colour_q};
                vga_we_d   = 1'b1;
            end
            StWrPix: begin
                if (cur_x_q < x_hi_q) begin
                    cur_x_d    = x_next;
                    state_d    = StSetX;
                    vga_addr_d = VGA_X_ADDR;
                    vga_data_d = x_next;
                    vga_we_d   = 1'b1;
                end else if (cur_y_q < y_hi_q) begin
                    cur_y_d    = y_next;
                    cur_x_d    = x_lo_q;
                    state_d    = StSetY;
                    vga_addr_d = VGA_Y_ADDR;
                    vga_data_d = {1'b0, y_next[6:0]};
                    vga_we_d   = 1'b1;
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort lets the write on the bus this cycle finish, then stops quietly.
        if (abort && busy_q) begin
            state_d  = StIdle;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            vga_we_d = 1'b0;
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            x_lo_q     <= 8'h00;
            x_hi_q     <= 8'h00;
            y_lo_q     <= 8'h00;
            y_hi_q     <= 8'h00;
            cur_x_q    <= 8'h00;
            cur_y_q    <= 8'h00;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vga_addr_q <= 8'h00;
            vga_data_q <= 8'h00;
            vga_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_lo_q     <= x_lo_d;
            x_hi_q     <= x_hi_d;
            y_lo_q     <= y_lo_d;
            y_hi_q     <= y_hi_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vga_addr_q <= vga_addr_d;
            vga_data_q <= vga_data_d;
            vga_we_q   <= vga_we_d;
        end
    end

    assign BUS_DATA_OUT = rdata_q;
    assign VGA_ADDR     = vga_addr_q;
    assign VGA_DATA     = vga_data_q;
    assign VGA_WE       = vga_we_q;
    assign BUSY         = busy_q;
    assign DONE_IRQ     = done_q;

endmodule
